plca_beacon_supervisor: RTL and testbench

- Clocked consumer of the clause 148 wait_beacon and beacon_timeout timers; sits directly downstream of the timer block, upstream of the PLCA control/data state machines.
- Sequences resync, beacon wait, coordinator beacon request and beacon supervision.
- Issues timer start strobes and qualifies timer done levels.
- Produces plca_status with miss-count hysteresis.

---
 rtl/plca_beacon_pkg.sv | 37 +++
 rtl/plca_timer_qualifier.sv | 53 +++++
 rtl/plca_beacon_supervisor.sv | 196 +++++++++++++++++++
 tb/tb_plca_beacon_supervisor.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plca_beacon_pkg.sv
// -----------------------------------------------------------------------------
// plca_beacon_pkg
// Shared definitions for the PLCA beacon supervisor:
//   - supervisor state encodings (3-bit, also exported on sup_state)
//   - counter widths for miss count, statistics and timer arm counters
//   - saturating increment helper for the miss counter
// -----------------------------------------------------------------------------
package plca_beacon_pkg;

    localparam int MISS_CNT_W = 4;
    localparam int STATS_W    = 16;
    localparam int ARM_W      = 2;

    localparam logic [2:0] ST_DISABLE     = 3'd0;
    localparam logic [2:0] ST_RESYNC      = 3'd1;
    localparam logic [2:0] ST_WAIT_BEACON = 3'd2;
    localparam logic [2:0] ST_SEND_BEACON = 3'd3;
    localparam logic [2:0] ST_SYNCED      = 3'd4;
    localparam logic [2:0] ST_TIMEOUT     = 3'd5;

    typedef enum logic [2:0] {
        SUP_DISABLE     = ST_DISABLE,
        SUP_RESYNC      = ST_RESYNC,
        SUP_WAIT_BEACON = ST_WAIT_BEACON,
        SUP_SEND_BEACON = ST_SEND_BEACON,
        SUP_SYNCED      = ST_SYNCED,
        SUP_TIMEOUT     = ST_TIMEOUT
    } sup_state_e;

    // Miss counter sticks at its maximum instead of wrapping.
    function automatic logic [MISS_CNT_W-1:0] miss_sat_inc(input logic [MISS_CNT_W-1:0] v);
        logic [MISS_CNT_W-1:0] r;
        r = (v == {MISS_CNT_W{1'b1}}) ? v : v + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/plca_timer_qualifier.sv
// -----------------------------------------------------------------------------
// plca_timer_qualifier
// Qualifies the done level of an external timer against the start strobes
// this block issued, so stale expiries from a previous run are not acted on.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset
//   strobe  in   registered (re)start strobe as seen by the timer
//   done    in   raw timer expiry level
//   done_q  out  qualified expiry (combinational from regs + done/strobe)
//
// Qualification rules:
//   - while strobe is high, done is discarded (the restart wins)
//   - arm counter loads ARM_DELAY on the strobe; done ignored until it is 0
//   - stale flag set on the strobe; cleared only once done is seen low, so a
//     done level held across a restart needs a fresh low->high edge
// -----------------------------------------------------------------------------
module plca_timer_qualifier
    import plca_beacon_pkg::*;
#(
    parameter int ARM_DELAY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    input  logic done,
    output logic done_q
);

    logic [ARM_W-1:0] arm_cnt;
    logic             stale;

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt <= '0;
            stale   <= 1'b0;
        end else if (strobe) begin
            arm_cnt <= ARM_W'(ARM_DELAY);
            stale   <= 1'b1;
        end else begin
            if (arm_cnt != '0) begin
                arm_cnt <= arm_cnt - 1'b1;
            end
            if (!done) begin
                stale <= 1'b0;
            end
        end
    end

    assign done_q = done && (arm_cnt == '0) && !stale && !strobe;

endmodule

// File: rtl/plca_beacon_supervisor.sv
// -----------------------------------------------------------------------------
// plca_beacon_supervisor
// Sequences resync, beacon wait, coordinator beacon request and beacon
// supervision on top of the wait_beacon / beacon_timeout timers, and derives
// plca_status with miss-count hysteresis.
//
// Parameters:
//   MISS_LIMIT  consecutive beacon timeouts before plca_status drops (1..15)
//   ARM_DELAY   cycles after a start strobe during which done is ignored (0..3)
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   plca_en                      enable level; low forces DISABLE
//   coord_allowed                node may act as coordinator
//   rx_beacon                    pulse, BEACON received
//   rx_activity                  level, non-beacon receive activity
//   tx_beacon_ack                pulse, own BEACON transmitted
//   wait_beacon_timer_done       raw timer expiry level
//   beacon_timeout_timer_done    raw timer expiry level
//   start_wait_beacon_timer      registered one-cycle restart strobe
//   start_beacon_timeout_timer   registered one-cycle restart strobe
//   tx_beacon_req                registered level request to send BEACON
//   plca_status                  registered synchronised indication
//   sup_state                    current state encoding (debug)
//   beacon_rx_cnt, beacon_to_cnt saturating statistics, only present when
//                                PLCA_BEACON_STATS_EN is defined
//
// Handshake: tx_beacon_req is a level held high from SEND_BEACON entry until
// the cycle after tx_beacon_ack (or rx_beacon) is sampled; the timer strobes
// are single-cycle and appear one cycle after the triggering input.
//
// Only beacons/acks seen while in SYNCED refresh plca_status and clear the
// miss counter; entering SYNCED alone does not, so repeated timeouts across
// resync cycles accumulate toward MISS_LIMIT.
// -----------------------------------------------------------------------------
module plca_beacon_supervisor
    import plca_beacon_pkg::*;
#(
    parameter int MISS_LIMIT = 2,
    parameter int ARM_DELAY  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               plca_en,
    input  logic               coord_allowed,
    input  logic               rx_beacon,
    input  logic               rx_activity,
    input  logic               tx_beacon_ack,
    input  logic               wait_beacon_timer_done,
    input  logic               beacon_timeout_timer_done,
    output logic               start_wait_beacon_timer,
    output logic               start_beacon_timeout_timer,
    output logic               tx_beacon_req,
    output logic               plca_status,
`ifdef PLCA_BEACON_STATS_EN
    output logic [STATS_W-1:0] beacon_rx_cnt,
    output logic [STATS_W-1:0] beacon_to_cnt,
`endif
    output logic [2:0]         sup_state
);

    sup_state_e            state, state_nxt;
    logic [MISS_CNT_W-1:0] miss_cnt, miss_nxt, miss_inc;
    logic                  sw_nxt, sb_nxt, req_nxt, status_nxt;
    logic                  wait_done_q, to_done_q;

    plca_timer_qualifier #(.ARM_DELAY(ARM_DELAY)) u_wait_qual (
        .clk    (clk),
        .reset  (reset),
        .strobe (start_wait_beacon_timer),
        .done   (wait_beacon_timer_done),
        .done_q (wait_done_q)
    );

    plca_timer_qualifier #(.ARM_DELAY(ARM_DELAY)) u_to_qual (
        .clk    (clk),
        .reset  (reset),
        .strobe (start_beacon_timeout_timer),
        .done   (beacon_timeout_timer_done),
        .done_q (to_done_q)
    );

    assign miss_inc = miss_sat_inc(miss_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                      <= SUP_DISABLE;
            start_wait_beacon_timer    <= 1'b0;
            start_beacon_timeout_timer <= 1'b0;
            tx_beacon_req              <= 1'b0;
            plca_status                <= 1'b0;
            miss_cnt                   <= '0;
        end else begin
            state                      <= state_nxt;
            start_wait_beacon_timer    <= sw_nxt;
            start_beacon_timeout_timer <= sb_nxt;
            tx_beacon_req              <= req_nxt;
            plca_status                <= status_nxt;
            miss_cnt                   <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sw_nxt     = 1'b0;
        sb_nxt     = 1'b0;
        req_nxt    = tx_beacon_req;
        status_nxt = plca_status;
        miss_nxt   = miss_cnt;
        if (!plca_en) begin
            state_nxt  = SUP_DISABLE;
            req_nxt    = 1'b0;
            status_nxt = 1'b0;
            miss_nxt   = '0;
        end else begin
            case (state)
                SUP_DISABLE: begin
                    req_nxt   = 1'b0;
                    state_nxt = SUP_RESYNC;
                end
                SUP_RESYNC: begin
                    if (rx_beacon) begin
                        sb_nxt    = 1'b1;
                        state_nxt = SUP_SYNCED;
                    end else begin
                        sw_nxt    = 1'b1;
                        state_nxt = SUP_WAIT_BEACON;
                    end
                end
                SUP_WAIT_BEACON: begin
                    // Priority: beacon, then restart on activity, then expiry.
                    if (rx_beacon) begin
                        sb_nxt    = 1'b1;
                        state_nxt = SUP_SYNCED;
                    end else if (rx_activity) begin
                        sw_nxt = 1'b1;
                    end else if (wait_done_q) begin
                        if (coord_allowed) begin
                            req_nxt   = 1'b1;
                            state_nxt = SUP_SEND_BEACON;
                        end else begin
                            state_nxt = SUP_RESYNC;
                        end
                    end
                end
                SUP_SEND_BEACON: begin
                    req_nxt = 1'b1;
                    if (rx_beacon || tx_beacon_ack) begin
                        req_nxt   = 1'b0;
                        sb_nxt    = 1'b1;
                        state_nxt = SUP_SYNCED;
                    end
                end
                SUP_SYNCED: begin
                    if (rx_beacon || tx_beacon_ack) begin
                        sb_nxt     = 1'b1;
                        miss_nxt   = '0;
                        status_nxt = 1'b1;
                    end else if (to_done_q) begin
                        state_nxt = SUP_TIMEOUT;
                    end
                end
                SUP_TIMEOUT: begin
                    miss_nxt = miss_inc;
                    if (miss_inc >= MISS_CNT_W'(MISS_LIMIT)) begin
                        status_nxt = 1'b0;
                    end
                    state_nxt = SUP_RESYNC;
                end
                default: begin
                    state_nxt = SUP_DISABLE;
                end
            endcase
        end
    end

    assign sup_state = state;

`ifdef PLCA_BEACON_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            beacon_rx_cnt <= '0;
            beacon_to_cnt <= '0;
        end else begin
            if (rx_beacon && (beacon_rx_cnt != {STATS_W{1'b1}})) begin
                beacon_rx_cnt <= beacon_rx_cnt + 1'b1;
            end
            // TIMEOUT lasts exactly one cycle, so each cycle is one entry.
            if ((state == SUP_TIMEOUT) && (beacon_to_cnt != {STATS_W{1'b1}})) begin
                beacon_to_cnt <= beacon_to_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_plca_beacon_supervisor.sv
// -----------------------------------------------------------------------------
// tb_plca_beacon_supervisor
// Directed stimulus with hand-computed expected snapshots. The driver pushes
// {cycle, state, strobes, req, status} into exp_q; the monitor pops and
// compares on the falling edge of the matching cycle, counts every strobe
// pulse, and performs end-of-phase checks when asked.
// Cycle n means the registers as updated by the n-th rising edge.
// -----------------------------------------------------------------------------
module tb_plca_beacon_supervisor;
    import plca_beacon_pkg::*;

    localparam int W = 39;

    logic       clk;
    logic       reset;
    logic       plca_en;
    logic       coord_allowed;
    logic       rx_beacon;
    logic       rx_activity;
    logic       tx_beacon_ack;
    logic       wait_beacon_timer_done;
    logic       beacon_timeout_timer_done;
    logic       start_wait_beacon_timer;
    logic       start_beacon_timeout_timer;
    logic       tx_beacon_req;
    logic       plca_status;
    logic [2:0] sup_state;
`ifdef PLCA_BEACON_STATS_EN
    logic [15:0] beacon_rx_cnt;
    logic [15:0] beacon_to_cnt;
`endif

    plca_beacon_supervisor #(.MISS_LIMIT(2), .ARM_DELAY(1)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .plca_en                    (plca_en),
        .coord_allowed              (coord_allowed),
        .rx_beacon                  (rx_beacon),
        .rx_activity                (rx_activity),
        .tx_beacon_ack              (tx_beacon_ack),
        .wait_beacon_timer_done     (wait_beacon_timer_done),
        .beacon_timeout_timer_done  (beacon_timeout_timer_done),
        .start_wait_beacon_timer    (start_wait_beacon_timer),
        .start_beacon_timeout_timer (start_beacon_timeout_timer),
        .tx_beacon_req              (tx_beacon_req),
        .plca_status                (plca_status),
`ifdef PLCA_BEACON_STATS_EN
        .beacon_rx_cnt              (beacon_rx_cnt),
        .beacon_to_cnt              (beacon_to_cnt),
`endif
        .sup_state                  (sup_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int exp_sw_n = 0;
    int exp_sb_n = 0;
    int obs_sw_n = 0;
    int obs_sb_n = 0;
    int phase_req = 0;
    int phase_done = 0;
    logic [W-1:0] e;
    logic [6:0]   act;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_at(input int c, input logic [2:0] st, input logic sw,
                             input logic sb, input logic req, input logic stat);
        exp_q.push_back({32'(c), st, sw, sb, req, stat});
        if (sw) exp_sw_n++;
        if (sb) exp_sb_n++;
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (phase_done < p && n < 10) begin
            tick();
            n++;
        end
        if (phase_done < p) begin
            $display("FAIL phase_wait phase=%0d done=%0d", p, phase_done);
            $fatal(1, "monitor did not complete phase");
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (start_wait_beacon_timer === 1'b1) obs_sw_n++;
        if (start_beacon_timeout_timer === 1'b1) obs_sb_n++;
        while (exp_q.size() > 0 && int'(exp_q[0][38:7]) <= cyc) begin
            e = exp_q.pop_front();
            act = {sup_state, start_wait_beacon_timer, start_beacon_timeout_timer,
                   tx_beacon_req, plca_status};
            total++;
            if (int'(e[38:7]) != cyc) begin
                bad++;
                $display("FAIL snap_missed cyc=%0d want_cyc=%0d", cyc, int'(e[38:7]));
            end else if (act !== e[6:0]) begin
                bad++;
                $display("FAIL snap cyc=%0d got st=%0d sw=%b sb=%b req=%b stat=%b want st=%0d sw=%b sb=%b req=%b stat=%b",
                         cyc, act[6:4], act[3], act[2], act[1], act[0],
                         e[6:4], e[3], e[2], e[1], e[0]);
            end
        end
        if (phase_req == 1 && phase_done == 0) begin
            total++;
            if (obs_sw_n != exp_sw_n) begin
                bad++;
                $display("FAIL wait_strobe_count got=%0d want=%0d", obs_sw_n, exp_sw_n);
            end
            total++;
            if (obs_sb_n != exp_sb_n) begin
                bad++;
                $display("FAIL to_strobe_count got=%0d want=%0d", obs_sb_n, exp_sb_n);
            end
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL queue_left got=%0d want=0", exp_q.size());
            end
`ifdef PLCA_BEACON_STATS_EN
            total++;
            if (beacon_rx_cnt !== 16'd3) begin
                bad++;
                $display("FAIL rx_cnt got=%0d want=3", beacon_rx_cnt);
            end
            total++;
            if (beacon_to_cnt !== 16'd2) begin
                bad++;
                $display("FAIL to_cnt got=%0d want=2", beacon_to_cnt);
            end
`endif
            phase_done = 1;
        end
        if (phase_req == 2 && phase_done == 1) begin
`ifdef PLCA_BEACON_STATS_EN
            total++;
            if (beacon_rx_cnt !== 16'hFFFF) begin
                bad++;
                $display("FAIL rx_cnt_sat got=%0d want=65535", beacon_rx_cnt);
            end
            total++;
            if (beacon_to_cnt !== 16'd2) begin
                bad++;
                $display("FAIL to_cnt_hold got=%0d want=2", beacon_to_cnt);
            end
`endif
            phase_done = 2;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        plca_en = 1'b1;
        coord_allowed = 1'b1;
        rx_beacon = 1'b0;
        rx_activity = 1'b0;
        tx_beacon_ack = 1'b0;
        wait_beacon_timer_done = 1'b0;
        beacon_timeout_timer_done = 1'b0;

        // Reset and release: DISABLE, RESYNC, WAIT_BEACON with one wait strobe.
        repeat (3) tick();
        expect_at(3, ST_DISABLE, 0, 0, 0, 0);
        reset = 1'b0;
        expect_at(4, ST_RESYNC, 0, 0, 0, 0);
        expect_at(5, ST_WAIT_BEACON, 1, 0, 0, 0);
        expect_at(6, ST_WAIT_BEACON, 0, 0, 0, 0);

        // Coordinator: wait expiry -> request, ack after a few cycles -> SYNCED.
        wait_to(7);
        wait_beacon_timer_done = 1'b1;
        expect_at(8, ST_SEND_BEACON, 0, 0, 1, 0);
        wait_to(8);
        wait_beacon_timer_done = 1'b0;
        expect_at(12, ST_SEND_BEACON, 0, 0, 1, 0);
        wait_to(12);
        tx_beacon_ack = 1'b1;
        expect_at(13, ST_SYNCED, 0, 1, 0, 0);
        wait_to(13);
        tx_beacon_ack = 1'b0;
        expect_at(14, ST_SYNCED, 0, 0, 0, 0);

        // Beacon in SYNCED sets status; first timeout keeps it.
        wait_to(15);
        rx_beacon = 1'b1;
        expect_at(16, ST_SYNCED, 0, 1, 0, 1);
        wait_to(16);
        rx_beacon = 1'b0;
        wait_to(19);
        beacon_timeout_timer_done = 1'b1;
        expect_at(20, ST_TIMEOUT, 0, 0, 0, 1);
        wait_to(20);
        beacon_timeout_timer_done = 1'b0;
        expect_at(21, ST_RESYNC, 0, 0, 0, 1);
        expect_at(22, ST_WAIT_BEACON, 1, 0, 0, 1);

        // Back to SYNCED via own beacon, second timeout drops status.
        wait_to(24);
        wait_beacon_timer_done = 1'b1;
        expect_at(25, ST_SEND_BEACON, 0, 0, 1, 1);
        wait_to(25);
        wait_beacon_timer_done = 1'b0;
        tx_beacon_ack = 1'b1;
        expect_at(26, ST_SYNCED, 0, 1, 0, 1);
        wait_to(26);
        tx_beacon_ack = 1'b0;
        wait_to(28);
        beacon_timeout_timer_done = 1'b1;
        expect_at(29, ST_TIMEOUT, 0, 0, 0, 1);
        wait_to(29);
        beacon_timeout_timer_done = 1'b0;
        expect_at(30, ST_RESYNC, 0, 0, 0, 0);

        // Stale wait done held across the restart strobe is ignored.
        wait_to(30);
        wait_beacon_timer_done = 1'b1;
        expect_at(31, ST_WAIT_BEACON, 1, 0, 0, 0);
        expect_at(32, ST_WAIT_BEACON, 0, 0, 0, 0);
        expect_at(34, ST_WAIT_BEACON, 0, 0, 0, 0);
        expect_at(36, ST_WAIT_BEACON, 0, 0, 0, 0);
        wait_to(36);
        wait_beacon_timer_done = 1'b0;
        expect_at(37, ST_WAIT_BEACON, 0, 0, 0, 0);
        wait_to(37);
        wait_beacon_timer_done = 1'b1;
        expect_at(38, ST_SEND_BEACON, 0, 0, 1, 0);
        wait_to(38);
        wait_beacon_timer_done = 1'b0;
        expect_at(39, ST_SEND_BEACON, 0, 0, 1, 0);

        // plca_en dropped while requesting.
        wait_to(39);
        plca_en = 1'b0;
        expect_at(40, ST_DISABLE, 0, 0, 0, 0);
        wait_to(40);
        plca_en = 1'b1;
        expect_at(41, ST_RESYNC, 0, 0, 0, 0);
        expect_at(42, ST_WAIT_BEACON, 1, 0, 0, 0);

        // rx_beacon and qualified wait done together: beacon wins.
        wait_to(44);
        rx_beacon = 1'b1;
        wait_beacon_timer_done = 1'b1;
        expect_at(45, ST_SYNCED, 0, 1, 0, 0);
        wait_to(45);
        rx_beacon = 1'b0;
        wait_beacon_timer_done = 1'b0;
        expect_at(46, ST_SYNCED, 0, 0, 0, 0);

        // Ack in SYNCED refreshes; disable clears status.
        wait_to(46);
        tx_beacon_ack = 1'b1;
        expect_at(47, ST_SYNCED, 0, 1, 0, 1);
        wait_to(47);
        tx_beacon_ack = 1'b0;
        plca_en = 1'b0;
        expect_at(48, ST_DISABLE, 0, 0, 0, 0);
        wait_to(48);
        plca_en = 1'b1;
        expect_at(49, ST_RESYNC, 0, 0, 0, 0);
        expect_at(50, ST_WAIT_BEACON, 1, 0, 0, 0);

        // Activity restart beats a qualified expiry in the same cycle.
        wait_to(52);
        rx_activity = 1'b1;
        wait_beacon_timer_done = 1'b1;
        expect_at(53, ST_WAIT_BEACON, 1, 0, 0, 0);
        wait_to(53);
        rx_activity = 1'b0;
        wait_beacon_timer_done = 1'b0;
        expect_at(54, ST_WAIT_BEACON, 0, 0, 0, 0);

        // Non-coordinator expiry -> RESYNC; beacon in RESYNC -> SYNCED.
        wait_to(55);
        coord_allowed = 1'b0;
        wait_beacon_timer_done = 1'b1;
        expect_at(56, ST_RESYNC, 0, 0, 0, 0);
        wait_to(56);
        wait_beacon_timer_done = 1'b0;
        coord_allowed = 1'b1;
        rx_beacon = 1'b1;
        expect_at(57, ST_SYNCED, 0, 1, 0, 0);
        wait_to(57);
        rx_beacon = 1'b0;
        expect_at(58, ST_SYNCED, 0, 0, 0, 0);

        wait_to(60);
        phase_req = 1;
        wait_phase(1);

`ifdef PLCA_BEACON_STATS_EN
        plca_en = 1'b0;
        rx_beacon = 1'b1;
        repeat (70000) tick();
        rx_beacon = 1'b0;
        tick();
`endif
        phase_req = 2;
        wait_phase(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
